data_memory_ctrl: RTL and testbench

Parametrised successor data memory for the RISC-V core's load/store stage.
- Adds byte/halfword/word access with RV32I sign/zero extension, little-endian byte lanes and byte-enable writes.
- Uses a valid/ready request handshake with a registered response and configurable wait states.
- Reports misaligned, out-of-range and illegal-size accesses as errors.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_ram_bank.sv | 28 ++
 rtl/data_memory_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - size encodings, FSM states and byte-enable helper for the data memory controller
package dmem_pkg;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Little-endian lane mask for a store of the given size at byte offset off.
   function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         SZ_B, SZ_BU: be = 4'b0001 << off;
         SZ_H, SZ_HU: be = off[1] ? 4'b1100 : 4'b0011;
         SZ_W:        be = 4'b1111;
         default:     be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// rtl/dmem_ram_bank.sv - word-wide synchronous RAM with byte write enables and registered read
module dmem_ram_bank #(
   parameter int DEPTH_WORDS = 2048,
   parameter int IDX_W       = 11
) (
   input  logic             clk,
   input  logic [3:0]       we,
   input  logic             re,
   input  logic [IDX_W-1:0] addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // rdata is only updated by a read, so it doubles as the load holding register.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - load/store data memory controller with error reporting and wait states
// Optional performance counters are enabled with the DMEM_PERF_CNT_EN macro.
module data_memory_ctrl
   import dmem_pkg::*;
#(
   parameter int                DEPTH_WORDS = 2048,
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                WAIT_CYCLES = 0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
`ifdef DMEM_PERF_CNT_EN
   ,
   output logic [31:0]       rd_count,
   output logic [31:0]       wr_count,
   output logic [31:0]       err_count
`endif
);

   localparam int         IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

   state_t            state, state_nxt;
   logic [3:0]        wait_cnt;
   logic              accept;
   logic [ADDR_W-1:0] offset, word_idx;
   logic              range_err, size_err, align_err, req_err;
   logic [3:0]        ram_we;
   logic              ram_re;
   logic [31:0]       ram_wdata, ram_rdata;
   logic              lat_we, lat_err;
   logic [2:0]        lat_size;
   logic [1:0]        lat_off;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       load_data;

   assign accept   = req_valid && (state == ST_IDLE);
   assign offset   = req_addr - BASE_ADDR;
   assign word_idx = offset >> 2;

   always_comb begin
      range_err = (req_addr < BASE_ADDR) || (word_idx >= ADDR_W'(DEPTH_WORDS));
      size_err  = 1'b0;
      align_err = 1'b0;
      case (req_size)
         SZ_B:         size_err = 1'b0;
         SZ_H, SZ_W:   size_err = 1'b0;
         SZ_BU, SZ_HU: size_err = req_we;
         default:      size_err = 1'b1;
      endcase
      case (req_size)
         SZ_H, SZ_HU: align_err = req_addr[0];
         SZ_W:        align_err = (req_addr[1:0] != 2'b00);
         default:     align_err = 1'b0;
      endcase
      req_err = range_err || size_err || align_err;
   end

   // Store data is replicated across lanes; the byte enable picks the target lanes.
   always_comb begin
      ram_wdata = req_wdata;
      case (req_size[1:0])
         2'b00:   ram_wdata = {4{req_wdata[7:0]}};
         2'b01:   ram_wdata = {2{req_wdata[15:0]}};
         default: ram_wdata = req_wdata;
      endcase
      ram_we = (accept && req_we && !req_err) ? byte_en(req_size, req_addr[1:0]) : 4'b0000;
      ram_re = accept && !req_we && !req_err;
   end

   dmem_ram_bank #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clk   (CLK),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (word_idx[IDX_W-1:0]),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            end
         end
         ST_WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ld_byte = ram_rdata[7:0];
      case (lat_off)
         2'd0: ld_byte = ram_rdata[7:0];
         2'd1: ld_byte = ram_rdata[15:8];
         2'd2: ld_byte = ram_rdata[23:16];
         2'd3: ld_byte = ram_rdata[31:24];
         default: ld_byte = ram_rdata[7:0];
      endcase
      ld_half   = lat_off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      load_data = ram_rdata;
      case (lat_size)
         SZ_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
         SZ_BU:   load_data = {24'h0, ld_byte};
         SZ_H:    load_data = {{16{ld_half[15]}}, ld_half};
         SZ_HU:   load_data = {16'h0, ld_half};
         default: load_data = ram_rdata;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         wait_cnt  <= 4'd0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            wait_cnt <= WAIT_INIT;
         end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         rsp_valid <= (state == ST_RESP);
         rsp_err   <= (state == ST_RESP) && lat_err;
         rsp_rdata <= (state == ST_RESP && !lat_err && !lat_we) ? load_data : 32'h0;
      end
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         lat_we   <= req_we;
         lat_err  <= req_err;
         lat_size <= req_size;
         lat_off  <= req_addr[1:0];
      end
   end

`ifdef DMEM_PERF_CNT_EN
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rd_count  <= 32'h0;
         wr_count  <= 32'h0;
         err_count <= 32'h0;
      end else if (state == ST_RESP) begin
         if (lat_err) begin
            if (err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
         end else if (lat_we) begin
            if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
         end else begin
            if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - self-checking bench for data_memory_ctrl (WAIT_CYCLES 0 and 3 instances)
module tb_data_memory_ctrl;

   localparam logic [31:0] BASE3  = 32'h0000_0100;
   localparam int          DEPTH3 = 64;

   logic        CLK = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_size = 3'b010;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;

   logic        ready0, rv0, er0, ready3, rv3, er3;
   logic [31:0] rd0, rd3;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] mref [logic [32:0]];
   int exp_cnt [2][3];

   always #5 CLK = ~CLK;

`ifdef DMEM_PERF_CNT_EN
   logic [31:0] rc0, wc0, ec0, rc3, wc3, ec3;
`endif

   data_memory_ctrl u_dut0 (
      .CLK(CLK), .RST_N(rst_n), .req_valid(req_valid && !sel), .req_ready(ready0),
      .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0)
`ifdef DMEM_PERF_CNT_EN
      , .rd_count(rc0), .wr_count(wc0), .err_count(ec0)
`endif
   );

   data_memory_ctrl #(.DEPTH_WORDS(DEPTH3), .BASE_ADDR(BASE3), .WAIT_CYCLES(3)) u_dut3 (
      .CLK(CLK), .RST_N(rst_n), .req_valid(req_valid && sel), .req_ready(ready3),
      .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3)
`ifdef DMEM_PERF_CNT_EN
      , .rd_count(rc3), .wr_count(wc3), .err_count(ec3)
`endif
   );

   assign req_ready = sel ? ready3 : ready0;
   assign rsp_valid = sel ? rv3 : rv0;
   assign rsp_rdata = sel ? rd3 : rd0;
   assign rsp_err   = sel ? er3 : er0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Byte-addressed reference: each access touches nb bytes starting at addr.
   task automatic model(input logic s, input logic we, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err);
      longint base, depth;
      int nb;
      logic [31:0] v;
      base  = s ? BASE3 : 0;
      depth = s ? DEPTH3 : 2048;
      err = 1'b0;
      nb  = 1;
      rd  = 32'h0;
      if (longint'(addr) < base) err = 1'b1;
      else if ((longint'(addr) - base) / 4 >= depth) err = 1'b1;
      case (sz)
         3'd0, 3'd4: nb = 1;
         3'd1, 3'd5: nb = 2;
         3'd2:       nb = 4;
         default:    err = 1'b1;
      endcase
      if (we && (sz == 3'd4 || sz == 3'd5)) err = 1'b1;
      if (addr % nb != 0) err = 1'b1;
      if (!err) begin
         if (we) begin
            for (int i = 0; i < nb; i++) mref[{s, addr + 32'(i)}] = 8'(wd >> (8 * i));
         end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v + (32'(mref[{s, addr + 32'(i)}]) << (8 * i));
            if (sz == 3'd0 && v >= 128) v = v - 256;
            if (sz == 3'd1 && v >= 32768) v = v - 65536;
            rd = v;
         end
      end
      if (err) exp_cnt[s][2]++;
      else if (we) exp_cnt[s][1]++;
      else exp_cnt[s][0]++;
   endtask

   task automatic txn(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd_o, output logic err_o);
      logic [31:0] erd;
      logic eerr;
      int n;
      model(sel, we, sz, addr, wd, erd, eerr);
      @(negedge CLK);
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge CLK);
         n++;
      end
      chk("ready_before_req", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_size = sz; req_addr = addr; req_wdata = wd;
      @(posedge CLK);
      #1 req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!rsp_valid && n < 50);
      chk("latency", 32'(n), sel ? 32'd5 : 32'd2);
      chk("rsp_rdata", rsp_rdata, erd);
      chk("rsp_err", 32'(rsp_err), 32'(eerr));
      rd_o  = rsp_rdata;
      err_o = rsp_err;
   endtask

   task automatic chk_cnt(input logic s);
`ifdef DMEM_PERF_CNT_EN
      chk("rd_count", s ? rc3 : rc0, 32'(exp_cnt[s][0]));
      chk("wr_count", s ? wc3 : wc0, 32'(exp_cnt[s][1]));
      chk("err_count", s ? ec3 : ec0, 32'(exp_cnt[s][2]));
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, erd, wd;
      logic        er, eer;
      logic [2:0]  sizes [8];
      logic        seen;
      int          n;
      sizes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
      for (int s = 0; s < 2; s++) for (int k = 0; k < 3; k++) exp_cnt[s][k] = 0;

      repeat (3) @(negedge CLK);
      rst_n = 1'b1;
      @(negedge CLK);
      chk("reset_ready", 32'(req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_rsp_err", 32'(rsp_err), 32'd0);
      chk_cnt(1'b0);

      txn(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, rd, er);
      chk("sw_rdata", rd, 32'h0);
      txn(1'b0, 3'd2, 32'h10, 32'h0, rd, er);
      chk("lw_deadbeef", rd, 32'hDEAD_BEEF);
      txn(1'b1, 3'd2, 32'h10, 32'h1122_3344, rd, er);
      txn(1'b1, 3'd0, 32'h13, 32'h0000_0080, rd, er);
      txn(1'b0, 3'd2, 32'h10, 32'h0, rd, er);
      chk("lw_after_sb", rd, 32'h8022_3344);
      txn(1'b0, 3'd0, 32'h13, 32'h0, rd, er);
      chk("lb_sext", rd, 32'hFFFF_FF80);
      txn(1'b0, 3'd4, 32'h13, 32'h0, rd, er);
      chk("lbu_zext", rd, 32'h0000_0080);
      txn(1'b0, 3'd1, 32'h11, 32'h0, rd, er);
      chk("lh_misaligned_err", 32'(er), 32'd1);
      txn(1'b1, 3'd2, 32'h12, 32'hFFFF_FFFF, rd, er);
      chk("sw_misaligned_err", 32'(er), 32'd1);
      txn(1'b0, 3'd2, 32'h10, 32'h0, rd, er);
      chk("lw_unchanged", rd, 32'h8022_3344);
      txn(1'b0, 3'd2, 32'(4 * 2048), 32'h0, rd, er);
      chk("lw_out_of_range", 32'(er), 32'd1);
      txn(1'b0, 3'd3, 32'h10, 32'h0, rd, er);
      chk("illegal_size", 32'(er), 32'd1);

      for (int w = 0; w < 32; w++) txn(1'b1, 3'd2, 32'(4 * w), $urandom, rd, er);
      for (int i = 0; i < 150; i++) begin
         wd = $urandom;
         if ($urandom_range(0, 9) == 0) txn(1'($urandom), sizes[$urandom_range(0, 7)],
                                            32'(4 * 2048) + $urandom_range(0, 63), wd, rd, er);
         else txn(1'($urandom), sizes[$urandom_range(0, 7)], $urandom_range(0, 127), wd, rd, er);
      end
      chk_cnt(1'b0);

      @(negedge CLK);
      sel = 1'b1;
      for (int w = 0; w < 8; w++) txn(1'b1, 3'd2, BASE3 + 32'(4 * w), $urandom, rd, er);
      txn(1'b0, 3'd2, BASE3 - 32'd4, 32'h0, rd, er);
      chk("below_base_err", 32'(er), 32'd1);
      txn(1'b0, 3'd2, BASE3 + 32'(4 * DEPTH3), 32'h0, rd, er);
      chk("top_range_err", 32'(er), 32'd1);

      // Back-to-back with req_valid held high through the wait states.
      @(negedge CLK);
      wd = $urandom;
      req_valid = 1'b1; req_we = 1'b1; req_size = 3'd2; req_addr = BASE3 + 32'h8; req_wdata = wd;
      for (int t = 0; t < 3; t++) begin
         model(1'b1, req_we, req_size, req_addr, req_wdata, erd, eer);
         @(posedge CLK);
         #1;
         case (t)
            0: begin req_we = 1'b0; req_size = 3'd2; req_addr = BASE3 + 32'h8; end
            1: begin req_we = 1'b0; req_size = 3'd0; req_addr = BASE3 + 32'h1; end
            default: req_valid = 1'b0;
         endcase
         for (int j = 1; j <= 5; j++) begin
            @(negedge CLK);
            chk("b2b_ready", 32'(req_ready), (j == 5) ? 32'd1 : 32'd0);
            chk("b2b_rsp_valid", 32'(rsp_valid), (j == 5) ? 32'd1 : 32'd0);
         end
         chk("b2b_rdata", rsp_rdata, erd);
         chk("b2b_err", 32'(rsp_err), 32'(eer));
      end
      chk_cnt(1'b1);

      // Reset while a store's response is pending in WAIT.
      @(negedge CLK);
      model(1'b1, 1'b1, 3'd2, BASE3 + 32'h20, 32'hA5A5_A5A5, erd, eer);
      req_valid = 1'b1; req_we = 1'b1; req_size = 3'd2; req_addr = BASE3 + 32'h20;
      req_wdata = 32'hA5A5_A5A5;
      @(posedge CLK);
      #1 req_valid = 1'b0;
      @(negedge CLK);
      rst_n = 1'b0;
      @(negedge CLK);
      rst_n = 1'b1;
      for (int s = 0; s < 2; s++) for (int k = 0; k < 3; k++) exp_cnt[s][k] = 0;
      chk("rst_mid_ready", 32'(req_ready), 32'd1);
      chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk_cnt(1'b1);
      seen = 1'b0;
      for (n = 0; n < 8; n++) begin
         @(negedge CLK);
         if (rsp_valid) seen = 1'b1;
      end
      chk("rsp_dropped", 32'(seen), 32'd0);
      txn(1'b0, 3'd2, BASE3 + 32'h20, 32'h0, rd, er);
      chk("store_survives_reset", rd, 32'hA5A5_A5A5);
      chk_cnt(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
